// File: rtl/col2img_writeback_pkg.sv
// Shared constants and FSM encoding for the col2img write-back block.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package col2img_writeback_pkg;

  localparam int DEF_S2P_SIZE         = 4;
  localparam int DEF_ACC_WIDTH        = 32;
  localparam int DEF_ADDR_SIZE        = 16;
  localparam int DEF_KERNEL_NUMS_SIZE = 8;
  localparam int DEF_TENSOR_SIZE      = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_TILE = 3'd2,
    DRAIN     = 3'd3,
    FIN       = 3'd4
  } wb_state_e;

endpackage

// File: rtl/col2img_writeback_if.sv
// Tile input handshake plus single-word memory write port of the write-back block.
// Latency: n/a (wires only).
// Backpressure: tile side valid/ready, write side en/ready.
interface col2img_writeback_if import col2img_writeback_pkg::*; #(
  parameter int S2P_SIZE  = DEF_S2P_SIZE,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
);
  logic                                    i_tile_valid;
  logic                                    o_tile_ready;
  logic [S2P_SIZE*S2P_SIZE*ACC_WIDTH-1:0]  i_tile_data;
  logic                                    o_wr_en;
  logic [ADDR_SIZE-1:0]                    o_wr_addr;
  logic [ACC_WIDTH-1:0]                    o_wr_data;
  logic                                    i_wr_ready;

  // The write-back block itself.
  modport slave (
    input  i_tile_valid, i_tile_data, i_wr_ready,
    output o_tile_ready, o_wr_en, o_wr_addr, o_wr_data
  );

  // Tile producer plus memory port on the other side.
  modport master (
    output i_tile_valid, i_tile_data, i_wr_ready,
    input  o_tile_ready, o_wr_en, o_wr_addr, o_wr_data
  );
endinterface

// File: rtl/col2img_writeback_wb_addr_gen.sv
// Tile/row/column walker producing channel-major write addresses and tile limits.
// Latency: combinational current/next view of registered counters; advances one element per step.
// Backpressure: counters only move on step, so a stalled write holds its position.
module wb_addr_gen import col2img_writeback_pkg::*; #(
  parameter int S2P_SIZE  = DEF_S2P_SIZE,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int KN_W      = DEF_KERNEL_NUMS_SIZE,
  parameter int PIX_W     = 2*DEF_TENSOR_SIZE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load,
  input  logic                            step,
  input  logic [KN_W-1:0]                 cfg_kernel_nums,
  input  logic [PIX_W-1:0]                cfg_out_pixels,
  input  logic [ADDR_SIZE-1:0]            cfg_base_addr,
  output logic                            empty,
  output logic                            last_elem,
  output logic                            last_tile,
  output logic [2*$clog2(S2P_SIZE)-1:0]   cur_idx,
  output logic [2*$clog2(S2P_SIZE)-1:0]   nxt_idx,
  output logic [ADDR_SIZE-1:0]            cur_addr,
  output logic [ADDR_SIZE-1:0]            nxt_addr
);
  localparam int LG = $clog2(S2P_SIZE);

  logic [KN_W-1:0]      kn_q, kt_tot, kt, nxt_kt;
  logic [PIX_W-1:0]     pix_q, pt_tot, pt, nxt_pt;
  logic [LG-1:0]        r, c, nxt_r, nxt_c;
  logic [ADDR_SIZE-1:0] kt_base, row_base, col_off;
  logic [ADDR_SIZE-1:0] nxt_kt_base, nxt_row_base, nxt_col_off;
  logic [ADDR_SIZE-1:0] pix_a, stride_kt;
  logic [LG:0]          row_lim, col_lim;
  logic                 last_kt, last_pt, last_row, last_col;

  assign pix_a     = ADDR_SIZE'(pix_q);
  assign stride_kt = pix_a << LG;
  assign last_kt   = (kt == kt_tot - 1'b1);
  assign last_pt   = (pt == pt_tot - 1'b1);
  // Only the final tile in each direction can be partial; its size is the remainder.
  assign row_lim   = (last_kt && kn_q[LG-1:0] != '0)  ? {1'b0, kn_q[LG-1:0]}  : (LG+1)'(S2P_SIZE);
  assign col_lim   = (last_pt && pix_q[LG-1:0] != '0) ? {1'b0, pix_q[LG-1:0]} : (LG+1)'(S2P_SIZE);
  assign last_row  = ({1'b0, r} == row_lim - 1'b1);
  assign last_col  = ({1'b0, c} == col_lim - 1'b1);
  assign last_elem = last_row && last_col;
  assign last_tile = last_kt && last_pt;
  assign empty     = (kn_q == '0) || (pix_q == '0);

  assign cur_idx  = {r, c};
  assign nxt_idx  = {nxt_r, nxt_c};
  assign cur_addr = row_base + col_off + ADDR_SIZE'(c);
  assign nxt_addr = nxt_row_base + nxt_col_off + ADDR_SIZE'(nxt_c);

  // Next element in r-outer/c-inner order, rolling into pt then kt at tile ends.
  always_comb begin
    nxt_r        = r;
    nxt_c        = c;
    nxt_pt       = pt;
    nxt_kt       = kt;
    nxt_kt_base  = kt_base;
    nxt_row_base = row_base;
    nxt_col_off  = col_off;
    if (!last_col) begin
      nxt_c = c + 1'b1;
    end else if (!last_row) begin
      nxt_c        = '0;
      nxt_r        = r + 1'b1;
      nxt_row_base = row_base + pix_a;
    end else begin
      nxt_c = '0;
      nxt_r = '0;
      if (!last_pt) begin
        nxt_pt       = pt + 1'b1;
        nxt_col_off  = col_off + ADDR_SIZE'(S2P_SIZE);
        nxt_row_base = kt_base;
      end else begin
        nxt_pt       = '0;
        nxt_col_off  = '0;
        nxt_kt       = kt + 1'b1;
        nxt_kt_base  = kt_base + stride_kt;
        nxt_row_base = kt_base + stride_kt;
      end
    end
  end

  // Config latch on start, then one element advance per accepted write.
  always_ff @(posedge clk) begin
    if (rst) begin
      kn_q <= '0; pix_q <= '0; kt_tot <= '0; pt_tot <= '0;
      kt <= '0; pt <= '0; r <= '0; c <= '0;
      kt_base <= '0; row_base <= '0; col_off <= '0;
    end else if (load) begin
      kn_q     <= cfg_kernel_nums;
      pix_q    <= cfg_out_pixels;
      kt_tot   <= (cfg_kernel_nums >> LG) + KN_W'(|cfg_kernel_nums[LG-1:0]);
      pt_tot   <= (cfg_out_pixels >> LG) + PIX_W'(|cfg_out_pixels[LG-1:0]);
      kt <= '0; pt <= '0; r <= '0; c <= '0;
      kt_base  <= cfg_base_addr;
      row_base <= cfg_base_addr;
      col_off  <= '0;
    end else if (step) begin
      kt <= nxt_kt; pt <= nxt_pt; r <= nxt_r; c <= nxt_c;
      kt_base  <= nxt_kt_base;
      row_base <= nxt_row_base;
      col_off  <= nxt_col_off;
    end
  end

endmodule

// File: rtl/col2img_writeback.sv
// Serialises GEMM result tiles into trimmed, channel-major single-word memory writes.
// Latency: first write the cycle after tile acceptance, then one write per accepted cycle.
// Backpressure: i_wr_ready low holds addr/data/en; tile ready only while waiting for a tile.
module col2img_writeback import col2img_writeback_pkg::*; #(
  parameter int S2P_SIZE  = DEF_S2P_SIZE,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int KN_W      = DEF_KERNEL_NUMS_SIZE,
  parameter int PIX_W     = 2*DEF_TENSOR_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KN_W-1:0]      cfg_kernel_nums,
  input  logic [PIX_W-1:0]     cfg_out_pixels,
  input  logic [ADDR_SIZE-1:0] cfg_base_addr,
  col2img_writeback_if.slave   bus,
  output logic                 o_busy,
  output logic                 o_done
);
  localparam int IDX_W = 2*$clog2(S2P_SIZE);
  localparam int TW    = S2P_SIZE*S2P_SIZE*ACC_WIDTH;

  wb_state_e            state_q, state_d;
  logic [TW-1:0]        tile_q, sel_src;
  logic [IDX_W-1:0]     cur_idx, nxt_idx, sel_idx;
  logic [ADDR_SIZE-1:0] cur_addr, nxt_addr, sel_addr;
  logic [ACC_WIDTH-1:0] sel_elem;
  logic                 empty, last_elem, last_tile, load, accept, step;

  assign load   = (state_q == IDLE) && start;
  assign accept = (state_q == WAIT_TILE) && bus.i_tile_valid && bus.o_tile_ready;
  assign step   = (state_q == DRAIN) && bus.o_wr_en && bus.i_wr_ready;

  wb_addr_gen #(
    .S2P_SIZE(S2P_SIZE), .ADDR_SIZE(ADDR_SIZE), .KN_W(KN_W), .PIX_W(PIX_W)
  ) u_addr_gen (
    .clk(clk), .rst(rst), .load(load), .step(step),
    .cfg_kernel_nums(cfg_kernel_nums), .cfg_out_pixels(cfg_out_pixels),
    .cfg_base_addr(cfg_base_addr),
    .empty(empty), .last_elem(last_elem), .last_tile(last_tile),
    .cur_idx(cur_idx), .nxt_idx(nxt_idx), .cur_addr(cur_addr), .nxt_addr(nxt_addr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; start outside IDLE is ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start) state_d = LOAD;
      LOAD:      state_d = empty ? FIN : WAIT_TILE;
      WAIT_TILE: if (accept) state_d = DRAIN;
      DRAIN:     if (step && last_elem) state_d = last_tile ? FIN : WAIT_TILE;
      FIN:       state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // At acceptance the first element comes straight off the bus; afterwards from the capture.
  always_comb begin
    sel_src  = (state_q == WAIT_TILE) ? bus.i_tile_data : tile_q;
    sel_idx  = (state_q == WAIT_TILE) ? cur_idx : nxt_idx;
    sel_addr = (state_q == WAIT_TILE) ? cur_addr : nxt_addr;
    sel_elem = '0;
    for (int i = 0; i < S2P_SIZE*S2P_SIZE; i++) begin
      if (sel_idx == IDX_W'(i)) sel_elem = sel_src[i*ACC_WIDTH +: ACC_WIDTH];
    end
  end

  // Tile capture so upstream may move on as soon as the tile is accepted.
  always_ff @(posedge clk) begin
    if (rst)         tile_q <= '0;
    else if (accept) tile_q <= bus.i_tile_data;
  end

  // Registered outputs; status flags decode the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.o_tile_ready <= 1'b0;
      bus.o_wr_en      <= 1'b0;
      bus.o_wr_addr    <= '0;
      bus.o_wr_data    <= '0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
    end else begin
      bus.o_tile_ready <= (state_d == WAIT_TILE);
      o_busy           <= state_d inside {LOAD, WAIT_TILE, DRAIN};
      o_done           <= (state_d == FIN);
      if (accept) begin
        bus.o_wr_en   <= 1'b1;
        bus.o_wr_addr <= sel_addr;
        bus.o_wr_data <= sel_elem;
      end else if (step) begin
        if (last_elem) begin
          bus.o_wr_en <= 1'b0;
        end else begin
          bus.o_wr_addr <= sel_addr;
          bus.o_wr_data <= sel_elem;
        end
      end
    end
  end

endmodule

// File: tb/tb_col2img_writeback.sv
// Randomised scoreboard bench for col2img_writeback against an arithmetic placement model.
// Latency: checks first-write, per-tile rate and done timing.
// Backpressure: drives i_wr_ready held, toggling and random.
module tb_col2img_writeback;
  import col2img_writeback_pkg::*;

  localparam int S   = DEF_S2P_SIZE;
  localparam int AW  = DEF_ACC_WIDTH;
  localparam int ADW = DEF_ADDR_SIZE;
  localparam int KNW = DEF_KERNEL_NUMS_SIZE;
  localparam int PXW = 2*DEF_TENSOR_SIZE;
  localparam int TW  = S*S*AW;

  typedef struct packed {
    logic [ADW-1:0] addr;
    logic [AW-1:0]  data;
  } wr_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [KNW-1:0] cfg_kernel_nums;
  logic [PXW-1:0] cfg_out_pixels;
  logic [ADW-1:0] cfg_base_addr;
  logic           o_busy, o_done;

  always #5 clk = ~clk;

  col2img_writeback_if #(.S2P_SIZE(S), .ACC_WIDTH(AW), .ADDR_SIZE(ADW)) bus ();

  col2img_writeback #(
    .S2P_SIZE(S), .ACC_WIDTH(AW), .ADDR_SIZE(ADW), .KN_W(KNW), .PIX_W(PXW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_kernel_nums(cfg_kernel_nums), .cfg_out_pixels(cfg_out_pixels),
    .cfg_base_addr(cfg_base_addr), .bus(bus), .o_busy(o_busy), .o_done(o_done)
  );

  int  n_total = 0, n_pass = 0, cyc = 0;
  wr_t exp_q[$];
  wr_t mon_e, hold_w;
  bit  hold_v = 0;
  int  rdy_mode = 0;
  int  n_writes, n_accepts, n_rdy_cycles, first_fire, last_fire, first_accept, done_cyc, start_edge;
  logic busy_at_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
  endtask

  // Memory-side ready pattern, changed just after each edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.i_wr_ready = 1'b1;
      1:       bus.i_wr_ready = ~bus.i_wr_ready;
      default: bus.i_wr_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: every write handshake pops the scoreboard; stalls must hold the word.
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 0;
    end else begin
      if (hold_v)
        check("stall_hold", {bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data}, {1'b1, hold_w});
      hold_v = 0;
      if (bus.o_wr_en && bus.i_wr_ready) begin
        n_writes++;
        last_fire = cyc + 1;
        if (first_fire < 0) first_fire = cyc + 1;
        check("write_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("write_addr_data", {bus.o_wr_addr, bus.o_wr_data}, mon_e);
        end
      end else if (bus.o_wr_en) begin
        hold_v      = 1;
        hold_w.addr = bus.o_wr_addr;
        hold_w.data = bus.o_wr_data;
      end
      if (bus.o_tile_ready) n_rdy_cycles++;
      if (bus.o_tile_ready && bus.i_tile_valid) begin
        n_accepts++;
        if (first_accept < 0) first_accept = cyc + 1;
      end
      if (o_done && done_cyc < 0) begin
        done_cyc     = cyc;
        busy_at_done = o_busy;
      end
    end
  end

  function automatic logic [TW-1:0] make_tile(input bit seq);
    logic [TW-1:0] t;
    for (int i = 0; i < S*S; i++) t[i*AW +: AW] = seq ? AW'(i) : AW'($urandom());
    return t;
  endfunction

  // Reference placement: element (r,c) of tile (kt,pt) lands at channel kt*S+r, pixel pt*S+c.
  task automatic push_expected(input int kn, input int pix, input logic [ADW-1:0] base,
                               input int kt, input int pt, input logic [TW-1:0] t);
    wr_t e;
    for (int r = 0; r < S; r++) begin
      for (int c = 0; c < S; c++) begin
        int k = kt*S + r;
        int p = pt*S + c;
        if (k < kn && p < pix) begin
          e.addr = ADW'(int'(base) + k*pix + p);
          e.data = t[(r*S+c)*AW +: AW];
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic send_tile(input logic [TW-1:0] t);
    bit got = 0;
    bus.i_tile_valid = 1'b1;
    bus.i_tile_data  = t;
    for (int w = 0; w < 500 && !got; w++) begin
      @(negedge clk);
      if (bus.o_tile_ready) got = 1;
    end
    check("tile_accepted", got, 1);
    @(posedge clk); #1;
    bus.i_tile_valid = 1'b0;
    bus.i_tile_data  = make_tile(0);
  endtask

  task automatic start_op(input int kn, input int pix, input logic [ADW-1:0] base);
    n_writes = 0; n_accepts = 0; n_rdy_cycles = 0;
    first_fire = -1; last_fire = -1; first_accept = -1; done_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1;
    cfg_kernel_nums = KNW'(kn);
    cfg_out_pixels  = PXW'(pix);
    cfg_base_addr   = base;
    start_edge      = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_rise", o_busy, 1);
  endtask

  task automatic run_op(input int kn, input int pix, input logic [ADW-1:0] base,
                        input int mode, input bit seq, input bit poke);
    int kt_n = (kn + S - 1) / S;
    int pt_n = (pix + S - 1) / S;
    logic [TW-1:0] t;
    rdy_mode = mode;
    start_op(kn, pix, base);
    for (int kt = 0; kt < kt_n; kt++) begin
      for (int pt = 0; pt < pt_n; pt++) begin
        t = make_tile(seq);
        push_expected(kn, pix, base, kt, pt, t);
        send_tile(t);
        if (poke && kt == 0 && pt == 0) begin
          start = 1'b1; cfg_kernel_nums = KNW'(1); cfg_out_pixels = PXW'(1); cfg_base_addr = '0;
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
    end
    for (int w = 0; w < 2000 && done_cyc < 0; w++) @(negedge clk);
    check("done_seen", done_cyc >= 0, 1);
    check("write_count", n_writes, kn*pix);
    check("queue_empty", exp_q.size(), 0);
    check("tile_count", n_accepts, kt_n*pt_n);
    check("busy_low_at_done", busy_at_done, 0);
    if (kn == 0 || pix == 0) begin
      check("empty_done_time", done_cyc, start_edge + 1);
      check("empty_no_ready", n_rdy_cycles, 0);
    end else begin
      check("done_after_last_write", done_cyc, last_fire);
    end
    if (mode == 0 && kn*pix > 0) check("first_write_latency", first_fire, first_accept + 1);
    if (mode == 0 && kt_n*pt_n == 1) check("single_tile_rate", last_fire - first_fire, kn*pix - 1);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [TW-1:0] t;
    rst = 1'b1; start = 1'b0;
    cfg_kernel_nums = '0; cfg_out_pixels = '0; cfg_base_addr = '0;
    bus.i_tile_valid = 1'b0; bus.i_tile_data = '0; bus.i_wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {bus.o_tile_ready, bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, o_busy, o_done}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op(4, 4, 16'h0100, 0, 1, 0);
    run_op(6, 9, ADW'($urandom()), 0, 0, 0);
    run_op(6, 9, ADW'($urandom()), 1, 0, 0);
    run_op(6, 9, 16'h0200, 0, 0, 1);
    run_op(0, 5, 16'h0300, 0, 0, 0);
    run_op(5, 0, 16'h0300, 0, 0, 0);
    run_op(4, 9, 16'hFFF0, 2, 0, 0);

    // Reset in the middle of draining a tile.
    rdy_mode = 0;
    start_op(8, 8, 16'h0040);
    t = make_tile(1);
    push_expected(8, 8, 16'h0040, 0, 0, t);
    send_tile(t);
    for (int w = 0; w < 50 && n_writes < 3; w++) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_drain_outputs", {bus.o_wr_en, o_busy, bus.o_tile_ready, o_done}, 4'b0000);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    run_op(5, 7, 16'h0080, 2, 0, 0);

    for (int i = 0; i < 4; i++)
      run_op($urandom_range(1, 11), $urandom_range(1, 18), ADW'($urandom()),
             $urandom_range(0, 2), 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/col2img_writeback.md
# col2img_writeback

- Output-side counterpart of the im2col front end: accepts `S2P_SIZE`×`S2P_SIZE` result tiles from the GEMM array and serialises them into single-word memory writes.
- Places each element at its channel-major position in the output feature map.
- Trims the zero-padded edge rows and columns of partial tiles, so only real results reach memory.
- Sits between the GEMM tile output and the output-feature-map RAM write port.

## Interface
Parameters:
- `S2P_SIZE`, 4: tile edge; power of two.
- `ACC_WIDTH`, 32: result element width.
- `ADDR_SIZE`, `` `ADDR_SIZE ``: memory address width.
- `KN_W`, `` `KERNEL_NUMS_SIZE ``: kernel-count width.
- `PIX_W`, 2×`` `TENSOR_SIZE ``: output-pixel-count width.

Ports:
- Reset: one clock; reset is synchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `start` in 1: one-cycle pulse; latches config.
- `cfg_kernel_nums` in `KN_W`: number of output channels.
- `cfg_out_pixels` in `PIX_W`: out_feature_size².
- `cfg_base_addr` in `ADDR_SIZE`: output map base address.
- `i_tile_valid` in 1: tile offered.
- `o_tile_ready` out 1: tile accepted on valid&ready.
- `i_tile_data` in `S2P_SIZE`²·`ACC_WIDTH`: element (r,c) at bits [(r·S2P_SIZE+c)·ACC_WIDTH +: ACC_WIDTH].
- `o_wr_en` out 1: write request.
- `o_wr_addr` out `ADDR_SIZE`: write address.
- `o_wr_data` out `ACC_WIDTH`: write data.
- `i_wr_ready` in 1: write accepted on en&ready.
- `o_busy` out 1: high from start until done.
- `o_done` out 1: one-cycle pulse after last write.

## Operation
- Tile counts are latched at `start`:
  - KT = ceil(kernel_nums/S2P_SIZE)
  - PT = ceil(pixels/S2P_SIZE)
  - Computed by shift plus remainder check.
- Tile order: kt outer (0..KT-1), pt inner (0..PT-1). The upstream GEMM tile order matches this.
- Per-tile limits:
  - row_lim = min(S2P_SIZE, kernel_nums−kt·S2P_SIZE)
  - col_lim = min(S2P_SIZE, pixels−pt·S2P_SIZE)
- Elements are written r outer, c inner, for r<row_lim and c<col_lim only. Padded positions cost no cycles.
- Address = base + (kt·S2P_SIZE+r)·pixels + pt·S2P_SIZE + c.
  - Generated incrementally with no multipliers: a row_base register adds `pixels` per row; the column offset increments by 1.
  - Width: `ADDR_SIZE`, wraps modulo 2^ADDR_SIZE.
- States:
  - IDLE → (start) LOAD.
  - LOAD → WAIT_TILE, or → FIN when kernel_nums==0 or pixels==0.
  - WAIT_TILE → (valid&ready) DRAIN.
  - DRAIN → (last element accepted) WAIT_TILE, or FIN after the last tile.
  - FIN → IDLE.
- `start` is ignored while `o_busy`.
- Tile contents are captured into an internal register on acceptance. Upstream may change `i_tile_data` afterwards.

## Timing
- Reset values: `o_tile_ready`=0, `o_wr_en`=0, `o_wr_addr`=0, `o_wr_data`=0, `o_busy`=0, `o_done`=0, state IDLE.
- `rst` mid-operation: state and counters are cleared on the next edge, the partial tile is discarded, and no further writes are issued.
- All outputs are registered.
- `o_busy` rises the cycle after `start`.
- `o_tile_ready` is high only in WAIT_TILE.
- The first `o_wr_en` is asserted the cycle after tile acceptance.
- With `i_wr_ready` held high, one write per cycle: a tile with n valid elements takes n cycles.
- `o_tile_ready` returns the cycle after the last write of the tile is accepted.
- While `o_wr_en`=1 and `i_wr_ready`=0, `o_wr_addr` and `o_wr_data` hold stable and `o_wr_en` stays high.
- `o_done` pulses the cycle after the final write is accepted, or 2 cycles after `start` in the empty case. `o_busy` falls together with `o_done`.

## Structure
- The shared define file holds:
  - `S2P_SIZE`, `ACC_WIDTH`, `ADDR_SIZE`.
  - State encoding localparams IDLE/LOAD/WAIT_TILE/DRAIN/FIN.
- One sub-module, `wb_addr_gen`, holds the row_base/col/kt/pt counters, limit computation, and last-element/last-tile flags.
- The top level holds the FSM, the tile capture register, the element mux, and the output registers.

## Test plan
- S2P=4, kernel_nums=4, pixels=4, base=0x100, tile elements 0..15:
  - 16 writes at 0x100..0x10F with data 0..15, one per cycle.
  - `o_done` pulses 1 cycle after the 16th write.
- kernel_nums=6, pixels=9:
  - 6 tiles accepted.
  - Last pt tile writes 1 column; kt=1 tiles write 2 rows.
  - Exactly 54 writes; each address base+k·9+p hit once with the expected data.
- Same as the previous case with `i_wr_ready` toggling every cycle:
  - Address and data are stable across stalls.
  - No duplicated or dropped writes; total 54.
- `start` while busy is ignored.
- kernel_nums=0: no `o_tile_ready`, no writes, `o_done` 2 cycles after `start`.
- `rst` asserted mid-DRAIN:
  - Next cycle: `o_wr_en`=0, `o_busy`=0, `o_tile_ready`=0.
  - A subsequent start/tile sequence completes correctly from tile (0,0).
